reg_bank: RTL
=============

REG_BANK -- requirements
Module: reg_bank

Interface
REQ-001 SHALL have parameter DATA_W, default 8, bit width of every register.
REQ-002 SHALL have parameter NUM_REGS, default 4, number of registers (range 2..256).
REQ-003 SHALL have parameter ADDR_W, default 2, address width (2**ADDR_W >= NUM_REGS).
REQ-004 SHALL have parameter RST_VAL, default 0, reset value loaded into every register.
REQ-005 SHALL have ports: clk  in  1  clock, rising edge; reset_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports: wr_valid  in  1  write request; wr_ready  out  1  write accept.
REQ-007 SHALL have ports: wr_addr  in  ADDR_W  write index; wr_data  in  DATA_W  write value; wr_mask  in  DATA_W  per-bit write enable.
REQ-008 SHALL have ports: rd_req  in  1  read request; rd_addr  in  ADDR_W  read index.
REQ-009 SHALL have ports: rd_data  out  DATA_W  read value; rd_valid  out  1  read-data strobe.
REQ-010 SHALL have ports: lock  in  1  write-protect request; err  out  1  access-error pulse.
REQ-011 SHALL have ports: regs_out  out  NUM_REGS*DATA_W  flat view of all registers, register i at bits [i*DATA_W +: DATA_W].
REQ-012 SHALL have ports: upd  out  NUM_REGS  per-register one-cycle update pulse.
REQ-013 SHALL have port par_err  out  1  parity error, present in both builds.

Function
REQ-014 Write SHALL be accepted on a rising edge with wr_valid & wr_ready; reg[a] <= (reg[a] & ~wr_mask) | (wr_data & wr_mask).
REQ-015 wr_ready SHALL be a registered output: 1 in UNLOCKED state, 0 in LOCKED state.
REQ-016 Lock FSM SHALL have two states, UNLOCKED and LOCKED.
REQ-017 Lock FSM SHALL move UNLOCKED->LOCKED on the edge where lock=1.
REQ-018 Lock FSM SHALL move LOCKED->UNLOCKED on the edge where lock=0; wr_ready follows one cycle after lock changes.
REQ-019 upd[a] SHALL pulse high for exactly one cycle after an accepted write to a, even if the value is unchanged; all other upd bits stay 0.
REQ-020 Reads SHALL have latency 1: rd_req at edge N -> rd_valid=1 and rd_data=reg[rd_addr] for cycle N+1; rd_valid=0 otherwise and rd_data holds its last value.
REQ-021 Read and write to the same address on the same edge SHALL return the OLD value; regs_out shows the new value the following cycle.
REQ-022 Write with wr_addr >= NUM_REGS SHALL be dropped, with no upd pulse and err=1 for one cycle.
REQ-023 Read with rd_addr >= NUM_REGS SHALL give rd_valid=1, rd_data=0 and err=1 for one cycle.
REQ-024 wr_valid while wr_ready=0 SHALL be ignored, with no error and no state change.
REQ-025 wr_mask=0 on an accepted write SHALL leave data unchanged but still pulse upd.
REQ-026 regs_out SHALL be driven directly from the storage flops, with no combinational path from inputs.

Reset
REQ-027 On reset_n=0 all registers SHALL asynchronously take RST_VAL.
REQ-028 On reset_n=0 the FSM SHALL take UNLOCKED, wr_ready=0 during reset, and wr_ready=1 on the first edge after release.
REQ-029 On reset_n=0 rd_data, rd_valid, err, upd and par_err SHALL be 0.
REQ-030 Reset asserted mid-read SHALL suppress the pending rd_valid.

Configuration
REQ-031 Macro REG_BANK_PARITY_EN, when defined, SHALL store one even-parity bit per register, computed on every accepted write and reset consistent with RST_VAL.
REQ-032 With REG_BANK_PARITY_EN defined, each read SHALL check parity; a mismatch gives par_err=1 alongside rd_valid for that cycle.
REQ-033 Without REG_BANK_PARITY_EN, no parity storage SHALL exist and par_err SHALL be tied to 0.

Verification
REQ-034 Reset, then read all 4 registers -> each returns 0x00 with rd_valid one cycle after rd_req; err=0.
REQ-035 Write addr 2, data 0xA5, mask 0xFF, then addr 2, data 0x00, mask 0x0F -> regs_out[23:16]=0xA0; upd=4'b0100 after each write.
REQ-036 Same-edge write addr 1 = 0x3C and read addr 1 (old value 0x00) -> rd_data=0x00; next read -> 0x3C.
REQ-037 lock=1, then write addr 0 = 0xFF -> wr_ready=0, reg0 unchanged, no upd; lock=0 -> wr_ready=1 one cycle later and the write is accepted.
REQ-038 NUM_REGS=3, write addr 3 and read addr 3 -> err pulses on each, rd_data=0x00, no upd.
REQ-039 With REG_BANK_PARITY_EN, force a storage bit flip on reg1, then read addr 1 -> par_err=1 with rd_valid; without the macro -> par_err stays 0.

Source files
------------

// File: rtl/reg_bank.sv
// Parameterised register bank with masked writes, a lock FSM gating writes, and 1-cycle reads.
// Optional per-register even parity is compiled in when REG_BANK_PARITY_EN is defined.
module reg_bank #(
  parameter int                 DATA_W   = 8,
  parameter int                 NUM_REGS = 4,
  parameter int                 ADDR_W   = 2,
  parameter logic [DATA_W-1:0]  RST_VAL  = '0
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         wr_valid,
  output logic                         wr_ready,
  input  logic [ADDR_W-1:0]            wr_addr,
  input  logic [DATA_W-1:0]            wr_data,
  input  logic [DATA_W-1:0]            wr_mask,
  input  logic                         rd_req,
  input  logic [ADDR_W-1:0]            rd_addr,
  output logic [DATA_W-1:0]            rd_data,
  output logic                         rd_valid,
  input  logic                         lock,
  output logic                         err,
  output logic [NUM_REGS*DATA_W-1:0]   regs_out,
  output logic [NUM_REGS-1:0]          upd,
  output logic                         par_err
);

  typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} lock_state_e;

  localparam logic [ADDR_W:0] NUM_REGS_W = (ADDR_W + 1)'(NUM_REGS);

  lock_state_e state_q, state_d;
  logic        wr_ready_q, wr_ready_d;

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] upd_q, upd_d;

  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              err_q, err_d;

  logic              wr_fire;
  logic              wr_in_range;
  logic              rd_in_range;
  logic [DATA_W-1:0] rd_word;

  // ---------------------------------------------------------------------------
  // Lock FSM; wr_ready is registered from the next state so it trails lock by one edge.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    state_d = state_q;
    case (state_q)
      UNLOCKED: if (lock)  state_d = LOCKED;
      LOCKED:   if (!lock) state_d = UNLOCKED;
      default:             state_d = UNLOCKED;
    endcase
    wr_ready_d = (state_d == UNLOCKED);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: sequential state uses non-blocking assignment so all flops update together.
      state_q    <= UNLOCKED;
      wr_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ready_q <= wr_ready_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Write path and read mux.
  // ---------------------------------------------------------------------------
  assign wr_fire     = wr_valid & wr_ready_q;
  assign wr_in_range = {1'b0, wr_addr} < NUM_REGS_W;
  assign rd_in_range = {1'b0, rd_addr} < NUM_REGS_W;

  always_comb begin
    regs_d = regs_q;
    upd_d  = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (wr_fire && wr_in_range && (wr_addr == ADDR_W'(i))) begin
        regs_d[i] = (regs_q[i] & ~wr_mask) | (wr_data & wr_mask);
        upd_d[i]  = 1'b1;
      end
    end
  end

  // Decoded rather than indexed so an out-of-range address reads as zero.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_addr == ADDR_W'(i)) rd_word = regs_q[i];
    end
  end

  always_comb begin
    rd_valid_d = rd_req;
    rd_data_d  = rd_req ? rd_word : rd_data_q;
    err_d      = (wr_fire & ~wr_in_range) | (rd_req & ~rd_in_range);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the bank is small and architecturally reset, so every storage flop is cleared.
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RST_VAL;
      upd_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      regs_q     <= regs_d;
      upd_q      <= upd_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      err_q      <= err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Optional even parity: one stored bit per register, checked on each in-range read.
  // ---------------------------------------------------------------------------
`ifdef REG_BANK_PARITY_EN
  logic [NUM_REGS-1:0] par_q, par_d;
  logic                par_err_q, par_err_d;
  logic                rd_par;

  always_comb begin
    par_d = par_q;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (upd_d[i]) par_d[i] = ^regs_d[i];
    end
  end

  always_comb begin
    rd_par = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_addr == ADDR_W'(i)) rd_par = par_q[i];
    end
    par_err_d = rd_req & rd_in_range & (rd_par != ^rd_word);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      par_q     <= {NUM_REGS{^RST_VAL}};
      par_err_q <= 1'b0;
    end else begin
      par_q     <= par_d;
      par_err_q <= par_err_d;
    end
  end

  assign par_err = par_err_q;
`else
  assign par_err = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Outputs, all straight from flops.
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_out[g*DATA_W +: DATA_W] = regs_q[g];
  end

  assign wr_ready = wr_ready_q;
  assign upd      = upd_q;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign err      = err_q;

endmodule
